// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received byte with its status strobes out.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_byte;
  logic       received;
  logic       framing_error;

  modport master (input rx, output rx_byte, received, framing_error);
  modport slave  (output rx, input rx_byte, received, framing_error);
endinterface

// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver: mid-bit sampling, one-cycle received and
// framing_error strobes, last good byte held on rx_byte between frames.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.master bus
);

  localparam int N  = CLKS_PER_BIT;
  localparam int H  = N / 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic [7:0]    byte_q;
  logic          recv_q;
  logic          ferr_q;

  assign rx_s              = sync_q[1];
  assign bus.rx_byte       = byte_q;
  assign bus.received      = recv_q;
  assign bus.framing_error = ferr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[0], bus.rx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      byte_q <= '0;
      recv_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      recv_q <= 1'b0;
      ferr_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            idx   <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leave at mid-stop-bit so a following start edge is never missed.
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              byte_q <= shreg;
              recv_q <= 1'b1;
              state  <= IDLE;
            end else begin
              ferr_q <= 1'b1;
              state  <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a vector table of single frames plus hand-built
// sequences for back-to-back, glitch, break, mid-frame reset and N=4 cases.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if b104 ();
  uart_rx_if b4 ();

  uart_rx #(.CLKS_PER_BIT(104)) u104 (.clk(clk), .rst_n(rst_n), .bus(b104));
  uart_rx #(.CLKS_PER_BIT(4))   u4   (.clk(clk), .rst_n(rst_n), .bus(b4));

  // Pulse recorders and protocol-violation counters, sampled on the falling edge.
  int         t104[$];
  logic [7:0] d104[$];
  int         t4[$];
  logic [7:0] d4[$];
  int         ferr104 = 0;
  int         ferr4 = 0;
  int         viol = 0;
  logic [7:0] pb104 = '0, pb4 = '0;
  logic       pr104 = 1'b0, pf104 = 1'b0, pr4 = 1'b0, pf4 = 1'b0;

  always @(negedge clk) begin
    if (b104.received) begin
      t104.push_back(cyc);
      d104.push_back(b104.rx_byte);
    end
    if (b4.received) begin
      t4.push_back(cyc);
      d4.push_back(b4.rx_byte);
    end
    if (b104.framing_error) ferr104 <= ferr104 + 1;
    if (b4.framing_error)   ferr4   <= ferr4 + 1;
    if (rst_n) begin
      if ((b104.received && (pr104 || b104.framing_error)) || (b104.framing_error && pf104) ||
          (b4.received && (pr4 || b4.framing_error)) || (b4.framing_error && pf4) ||
          (b104.rx_byte != pb104 && !b104.received) || (b4.rx_byte != pb4 && !b4.received))
        viol <= viol + 1;
    end
    pb104 <= b104.rx_byte;
    pb4   <= b4.rx_byte;
    pr104 <= b104.received;
    pf104 <= b104.framing_error;
    pr4   <= b4.received;
    pf4   <= b4.framing_error;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All waits end 1 time unit after a rising edge, so line changes never race the clock.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) b104.rx = v;
    else            b4.rx = v;
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; line is left at the stop level.
  task automatic send(input int which, input int n, input logic [7:0] d, input logic stop);
    set_rx(which, 1'b0);
    wait_cyc(n);
    for (int i = 0; i < 8; i++) begin
      set_rx(which, d[i]);
      wait_cyc(n);
    end
    set_rx(which, stop);
    wait_cyc(n);
  endtask

  task automatic frame(input int which, input int n, input logic [7:0] d);
    send(which, n, d, 1'b1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_byte;
    int         exp_rcv;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #(400000 * 10);
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base_n, base_f, fall_cyc;

    vecs[0] = '{8'h2A, 1'b1, 8'h2A, 1, 0};
    vecs[1] = '{8'h67, 1'b1, 8'h67, 1, 0};
    vecs[2] = '{8'h5A, 1'b0, 8'h67, 0, 1};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 1, 0};
    vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    vecs[5] = '{8'h80, 1'b1, 8'h80, 1, 0};
    vecs[6] = '{8'h01, 1'b1, 8'h01, 1, 0};

    b104.rx = 1'b1;
    b4.rx   = 1'b1;
    rst_n   = 1'b0;
    wait_cyc(5);
    check("reset_byte", {24'd0, b104.rx_byte}, 32'h00);
    check("reset_recv", {31'd0, b104.received}, 32'd0);
    check("reset_ferr", {31'd0, b104.framing_error}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(2000);
    check("idle_recv_count", t104.size() + t4.size(), 32'd0);
    check("idle_ferr_count", ferr104 + ferr4, 32'd0);
    check("idle_byte", {24'd0, b104.rx_byte}, 32'h00);

    foreach (vecs[i]) begin
      base_n = t104.size();
      base_f = ferr104;
      send(0, 104, vecs[i].data, vecs[i].stop);
      set_rx(0, 1'b1);
      wait_cyc(200);
      check($sformatf("vec%0d_rcv", i), t104.size() - base_n, vecs[i].exp_rcv);
      check($sformatf("vec%0d_ferr", i), ferr104 - base_f, vecs[i].exp_ferr);
      check($sformatf("vec%0d_byte", i), {24'd0, b104.rx_byte}, {24'd0, vecs[i].exp_byte});
    end

    // Back-to-back tuning-word bytes: spacing 10N, first pulse 990 edges after
    // the edge that first captures the falling line.
    base_n   = t104.size();
    fall_cyc = cyc;
    frame(0, 104, 8'h2A);
    frame(0, 104, 8'h67);
    frame(0, 104, 8'h02);
    frame(0, 104, 8'h00);
    wait_cyc(300);
    check("b2b_count", t104.size() - base_n, 32'd4);
    if (t104.size() - base_n == 4) begin
      check("b2b_latency", t104[base_n] - fall_cyc - 1, 32'd990);
      check("b2b_byte0", {24'd0, d104[base_n]},     32'h2A);
      check("b2b_byte1", {24'd0, d104[base_n + 1]}, 32'h67);
      check("b2b_byte2", {24'd0, d104[base_n + 2]}, 32'h02);
      check("b2b_byte3", {24'd0, d104[base_n + 3]}, 32'h00);
      for (int k = 1; k < 4; k++)
        check($sformatf("b2b_gap%0d", k), t104[base_n + k] - t104[base_n + k - 1], 32'd1040);
    end

    // Glitch shorter than half a bit
    base_n = t104.size();
    base_f = ferr104;
    set_rx(0, 1'b0);
    wait_cyc(30);
    set_rx(0, 1'b1);
    wait_cyc(300);
    check("glitch_rcv", t104.size() - base_n, 32'd0);
    check("glitch_ferr", ferr104 - base_f, 32'd0);
    frame(0, 104, 8'h55);
    wait_cyc(100);
    check("post_glitch_rcv", t104.size() - base_n, 32'd1);
    check("post_glitch_byte", {24'd0, b104.rx_byte}, 32'h55);

    // Framing error followed by a long break
    base_n = t104.size();
    base_f = ferr104;
    send(0, 104, 8'hA3, 1'b0);
    wait_cyc(3000);
    check("break_ferr", ferr104 - base_f, 32'd1);
    check("break_rcv", t104.size() - base_n, 32'd0);
    check("break_byte", {24'd0, b104.rx_byte}, 32'h55);
    set_rx(0, 1'b1);
    wait_cyc(200);
    frame(0, 104, 8'h3C);
    wait_cyc(100);
    check("post_break_byte", {24'd0, b104.rx_byte}, 32'h3C);
    check("post_break_ferr", ferr104 - base_f, 32'd1);

    // Reset during data bit 4 of 0xFF
    base_n = t104.size();
    set_rx(0, 1'b0);
    wait_cyc(104);
    set_rx(0, 1'b1);
    wait_cyc(4 * 104 + 52);
    rst_n = 1'b0;
    wait_cyc(5);
    check("midreset_byte", {24'd0, b104.rx_byte}, 32'h00);
    rst_n = 1'b1;
    wait_cyc(3 * 104 + 300);
    check("midreset_rcv", t104.size() - base_n, 32'd0);
    frame(0, 104, 8'h81);
    wait_cyc(100);
    check("post_reset_rcv", t104.size() - base_n, 32'd1);
    check("post_reset_byte", {24'd0, b104.rx_byte}, 32'h81);

    // Minimum divider
    base_n = t4.size();
    frame(1, 4, 8'h00);
    frame(1, 4, 8'hFF);
    wait_cyc(20);
    check("n4_count", t4.size() - base_n, 32'd2);
    if (t4.size() - base_n == 2) begin
      check("n4_byte0", {24'd0, d4[base_n]},     32'h00);
      check("n4_byte1", {24'd0, d4[base_n + 1]}, 32'hFF);
      check("n4_gap", t4[base_n + 1] - t4[base_n], 32'd40);
    end
    check("n4_ferr", ferr4, 32'd0);

    check("strobe_protocol", viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver (8N1) for the FTDI link into the DDS. It sits directly upstream of `communication`, and converts the `rx` line into one byte plus a one-cycle `received` strobe per frame. Those two signals drive `communication`'s `rx_byte`/`received` inputs. It runs on the same 12 MHz clock as the rest of the design.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 104: clock cycles per bit (12 MHz / 115200 baud, truncated). Legal values are 4 or more.

Ports:
- `clk`  input  1  system clock, 12 MHz; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `rx`  input  1  serial line, asynchronous to `clk`, idle high.
- `rx_byte`  output  8  last correctly framed byte; holds its value between frames.
- `received`  output  1  high for exactly one cycle when `rx_byte` has just been updated.
- `framing_error`  output  1  high for exactly one cycle when the stop bit is sampled low.

## Operation

- **Synchronizer:** `rx` passes through a 2-flop synchronizer (reset value 1); the FSM reads only the synchronized output `rx_s`.
- **Constants:** N = `CLKS_PER_BIT`, H = N/2 (integer floor). Counter width is $clog2(N). The bit index is 3 bits.
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE**
  - `rx_s`=0 → START with cnt=0.
  - Otherwise stay.
- **START**
  - cnt increments each cycle.
  - At cnt==H-1: if `rx_s`=0 → DATA with cnt=0, idx=0. If `rx_s`=1 (glitch) → IDLE with no output.
- **DATA**
  - cnt increments each cycle.
  - At cnt==N-1: cnt=0, `rx_s` shifts into bit 7 of the shift register (shift right, LSB first), idx increments.
  - After the 8th sample → STOP.
- **STOP**
  - At cnt==N-1: if `rx_s`=1 → `rx_byte` loads the shift register, `received` pulses, next state IDLE.
  - If `rx_s`=0 → `framing_error` pulses, `rx_byte` is unchanged, next state WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s`=1, then → IDLE. A held-low line (break) therefore produces exactly one `framing_error`, not a repeating one.
- Returning to IDLE at mid-stop-bit is intentional, so back-to-back frames with a single stop bit are received without loss.
- The shift register is internal and never visible on `rx_byte` mid-frame.

## Timing

- **Reset values:** state IDLE, cnt 0, idx 0, shift register 0x00, synchronizer flops 1, `rx_byte` 0x00, `received` 0, `framing_error` 0.
- **Reset assertion:** takes effect immediately and asynchronously, including mid-frame. The partial byte is discarded, and no `received` or `framing_error` pulse is issued for it.
- **Latency:**
  - Define edge e0 as the one where IDLE samples `rx_s`=0.
  - Start bit is sampled at e(H), data bit k (k=0..7) at e(H+(k+1)N), stop bit at e(H+9N).
  - `received` is high in the cycle after e(H+9N). For N=104 that is 988 edges after e0, and 990 edges after the `rx` pin falls, counting the synchronizer.
- **Outputs:** `received` and `framing_error` are registered, mutually exclusive, and never longer than 1 cycle.
- **`rx_byte` update:** changes only on the same edge that raises `received`, and is stable for at least one full frame afterwards.
- **Tolerance:** with N=104, sampling at mid-bit tolerates roughly ±4% cumulative baud mismatch over 10 bits.
- **Downstream contract:** `communication` samples `rx_byte` while `received`=1. No backpressure exists, and the downstream block must accept one byte per 10N cycles.

## Test plan

- **Reset:** hold `rst_n`=0 then release with `rx`=1 → `rx_byte`=0x00, `received`=0 and `framing_error`=0 for 2000 cycles.
- **Tuning-word bytes:** send 0x2A, 0x67, 0x02, 0x00 back-to-back at N=104 (the LSB-first bytes of m=157482) → four `received` pulses, 1040 cycles apart. `rx_byte` is 0x2A, 0x67, 0x02, 0x00 at each pulse, and the first pulse arrives 990 cycles after the first falling edge.
- **Glitch rejection:** pulse `rx` low for 30 cycles, then high → no `received`, no `framing_error`, FSM back in IDLE. A following 0x55 is received correctly.
- **Framing error:** send 0xA3 with the stop bit driven 0, then hold `rx` low for 3000 cycles → exactly one `framing_error` pulse, `rx_byte` keeps its prior value. After `rx` returns high, a frame of 0x3C is received as 0x3C.
- **Reset mid-frame:** assert `rst_n` low during data bit 4 of 0xFF, release, then send 0x81 → no pulse for 0xFF. `rx_byte`=0x81 with a single `received` pulse.
- **Minimum divider:** use N=4 (H=2) and send 0x00 then 0xFF → `rx_byte` 0x00 then 0xFF. `received` pulses 40 cycles apart.
